// File: rtl/usb3_ep0out_buf_pkg.sv
// Shared definitions for the EP0 OUT receive buffer: FSM states and
// the control-endpoint max packet size.
package usb3_ep0out_buf_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  localparam int unsigned EP0_MAX_PKT_BYTES = 512;

endpackage

// File: rtl/usb3_ep0out_ram.sv
// 32-bit payload RAM: synchronous write, registered read on a separate
// address, shaped so it maps onto a block RAM.
module usb3_ep0out_ram #(
  parameter int unsigned DEPTH_W = 128,
  parameter int unsigned ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wadr,
  input  logic [31:0]       wdat,
  input  logic [ADDR_W-1:0] radr,
  output logic [31:0]       rdat
);

  logic [31:0] mem [DEPTH_W];

  // Array has no reset so it stays inferable as block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wadr] <= wdat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdat <= '0;
    end else begin
      rdat <= mem[radr];
    end
  end

endmodule

// File: rtl/usb3_ep0out_buf.sv
// EP0 OUT data-stage buffer: receives a packet, commits or discards it at
// packet end, holds it for the reader and tracks the expected sequence.
module usb3_ep0out_buf
  import usb3_ep0out_buf_pkg::*;
#(
  parameter int unsigned DEPTH_W = EP0_MAX_PKT_BYTES / 4,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned LEN_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_start,
  input  logic [4:0]        wr_seq,
  input  logic              wr_we,
  input  logic [31:0]       wr_dat,
  input  logic              wr_end,
  input  logic              wr_crc_ok,
  input  logic [1:0]        wr_last_bytes,
  input  logic              seq_clr,
  output logic              ep_ready,
  output logic              pkt_ack,
  output logic              pkt_err,
  output logic              pkt_valid,
  output logic [LEN_W-1:0]  pkt_len,
  input  logic [ADDR_W-1:0] rd_adr,
  output logic [31:0]       rd_dat,
  input  logic              rd_release,
  output logic [4:0]        exp_seq
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH_W);

  state_t          state, state_nxt;
  logic [ADDR_W:0] wcnt;
  logic            ovf;
  logic [4:0]      seq_lat;
  logic            crc_lat;
  logic [1:0]      lb_lat;
  logic            start_acc;
  logic            ram_we;
  logic            commit_ok;
  logic [2:0]      last_bytes;
  logic [LEN_W-1:0] len_calc;

  // A start is only taken when the buffer is (or is being made) free.
  assign start_acc = wr_start &&
                     ((state == ST_EMPTY) || (state == ST_FULL && rd_release));
  assign ram_we    = (state == ST_RECV) && wr_we && (wcnt != DEPTH_CNT);
  assign commit_ok = crc_lat && !ovf && (seq_lat == exp_seq);

  assign last_bytes = (lb_lat == 2'd0) ? 3'd4 : {1'b0, lb_lat};
  assign len_calc   = (wcnt == '0) ? '0 :
                      (LEN_W'(wcnt) << 2) - LEN_W'(3'd4) + LEN_W'(last_bytes);

  assign ep_ready  = (state == ST_EMPTY);
  assign pkt_valid = (state == ST_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // seq_clr wins over the CHECK verdict, so no ack/err is emitted then.
  always_comb begin
    state_nxt = state;
    pkt_ack   = 1'b0;
    pkt_err   = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (wr_start) state_nxt = ST_RECV;
      end
      ST_RECV: begin
        if (seq_clr)     state_nxt = ST_EMPTY;
        else if (wr_end) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (seq_clr) begin
          state_nxt = ST_EMPTY;
        end else if (commit_ok) begin
          pkt_ack   = 1'b1;
          state_nxt = ST_FULL;
        end else begin
          pkt_err   = 1'b1;
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (rd_release && wr_start) state_nxt = ST_RECV;
        else if (rd_release)        state_nxt = ST_EMPTY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt    <= '0;
      ovf     <= 1'b0;
      seq_lat <= '0;
      crc_lat <= 1'b0;
      lb_lat  <= '0;
      pkt_len <= '0;
      exp_seq <= '0;
    end else begin
      if (start_acc) begin
        wcnt    <= '0;
        ovf     <= 1'b0;
        seq_lat <= wr_seq;
      end else if (state == ST_RECV) begin
        if (wr_we) begin
          if (wcnt == DEPTH_CNT) ovf <= 1'b1;
          else                   wcnt <= wcnt + 1'b1;
        end
        if (wr_end) begin
          crc_lat <= wr_crc_ok;
          lb_lat  <= wr_last_bytes;
        end
      end
      if (pkt_ack) pkt_len <= len_calc;
      if (seq_clr)      exp_seq <= '0;
      else if (pkt_ack) exp_seq <= exp_seq + 5'd1;
    end
  end

  usb3_ep0out_ram #(
    .DEPTH_W (DEPTH_W),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .wadr  (wcnt[ADDR_W-1:0]),
    .wdat  (wr_dat),
    .radr  (rd_adr),
    .rdat  (rd_dat)
  );

endmodule

// File: tb/tb_usb3_ep0out_buf.sv
// Directed self-checking bench for the EP0 OUT receive buffer.
module tb_usb3_ep0out_buf;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_start = 1'b0;
  logic [4:0]  wr_seq = '0;
  logic        wr_we = 1'b0;
  logic [31:0] wr_dat = '0;
  logic        wr_end = 1'b0;
  logic        wr_crc_ok = 1'b0;
  logic [1:0]  wr_last_bytes = '0;
  logic        seq_clr = 1'b0;
  logic        ep_ready, pkt_ack, pkt_err, pkt_valid;
  logic [9:0]  pkt_len;
  logic [6:0]  rd_adr = '0;
  logic [31:0] rd_dat;
  logic        rd_release = 1'b0;
  logic [4:0]  exp_seq;

  int checks = 0;
  int errors = 0;

  usb3_ep0out_buf #(.DEPTH_W(128), .ADDR_W(7), .LEN_W(10)) dut (
    .clk(clk), .reset(reset), .wr_start(wr_start), .wr_seq(wr_seq),
    .wr_we(wr_we), .wr_dat(wr_dat), .wr_end(wr_end), .wr_crc_ok(wr_crc_ok),
    .wr_last_bytes(wr_last_bytes), .seq_clr(seq_clr), .ep_ready(ep_ready),
    .pkt_ack(pkt_ack), .pkt_err(pkt_err), .pkt_valid(pkt_valid),
    .pkt_len(pkt_len), .rd_adr(rd_adr), .rd_dat(rd_dat),
    .rd_release(rd_release), .exp_seq(exp_seq)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Drive helpers: each starts and ends at a falling edge.
  task automatic start_pkt(input logic [4:0] s);
    wr_start = 1'b1; wr_seq = s;
    @(negedge clk);
    wr_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    wr_we = 1'b1; wr_dat = d;
    @(negedge clk);
    wr_we = 1'b0;
  endtask

  task automatic end_pkt(input logic crc, input logic [1:0] lb, output logic a, output logic e);
    wr_end = 1'b1; wr_crc_ok = crc; wr_last_bytes = lb;
    @(posedge clk); #1;
    a = pkt_ack; e = pkt_err;
    @(negedge clk);
    wr_end = 1'b0;
  endtask

  task automatic release_buf();
    rd_release = 1'b1;
    @(negedge clk);
    rd_release = 1'b0;
  endtask

  task automatic read_word(input logic [6:0] a, output logic [31:0] d);
    rd_adr = a;
    @(posedge clk); #1;
    d = rd_dat;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ep_ready !== 1'b1) begin errors++; $display("FAIL rst_ep_ready got %0b exp 1", ep_ready); end
    checks++; if (pkt_ack !== 1'b0 || pkt_err !== 1'b0) begin errors++; $display("FAIL rst_pulses got %0b%0b exp 00", pkt_ack, pkt_err); end
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL rst_pkt_valid got %0b exp 0", pkt_valid); end
    checks++; if (pkt_len !== 10'd0) begin errors++; $display("FAIL rst_pkt_len got %0d exp 0", pkt_len); end
    checks++; if (rd_dat !== 32'h0) begin errors++; $display("FAIL rst_rd_dat got %h exp 0", rd_dat); end
    checks++; if (exp_seq !== 5'd0) begin errors++; $display("FAIL rst_exp_seq got %0d exp 0", exp_seq); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_commit();
    logic a, e;
    logic [31:0] d;
    start_pkt(5'd0);
    send_word(32'h04030201);
    send_word(32'h08070605);
    send_word(32'h0C0B0A09);
    end_pkt(1'b1, 2'd2, a, e);
    checks++; if (a !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL commit_ack got %0b%0b exp 10", a, e); end
    checks++; if (ep_ready !== 1'b0) begin errors++; $display("FAIL commit_check_ready got %0b exp 0", ep_ready); end
    @(posedge clk); #1;
    checks++; if (pkt_ack !== 1'b0) begin errors++; $display("FAIL commit_ack_width got %0b exp 0", pkt_ack); end
    checks++; if (pkt_len !== 10'd10) begin errors++; $display("FAIL commit_len got %0d exp 10", pkt_len); end
    checks++; if (exp_seq !== 5'd1) begin errors++; $display("FAIL commit_exp_seq got %0d exp 1", exp_seq); end
    checks++; if (pkt_valid !== 1'b1 || ep_ready !== 1'b0) begin errors++; $display("FAIL commit_full got %0b%0b exp 10", pkt_valid, ep_ready); end
    @(negedge clk);
    read_word(7'd0, d);
    checks++; if (d !== 32'h04030201) begin errors++; $display("FAIL commit_rd0 got %h exp 04030201", d); end
    read_word(7'd1, d);
    checks++; if (d !== 32'h08070605) begin errors++; $display("FAIL commit_rd1 got %h exp 08070605", d); end
    read_word(7'd2, d);
    checks++; if (d !== 32'h0C0B0A09) begin errors++; $display("FAIL commit_rd2 got %h exp 0C0B0A09", d); end
  endtask

  task automatic test_busy();
    logic a, e;
    logic [31:0] d;
    start_pkt(5'd1);
    send_word(32'hDEADBEEF);
    send_word(32'hCAFEF00D);
    end_pkt(1'b1, 2'd0, a, e);
    checks++; if (a !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL busy_no_pulse got %0b%0b exp 00", a, e); end
    checks++; if (pkt_valid !== 1'b1 || pkt_len !== 10'd10) begin errors++; $display("FAIL busy_hold got valid=%0b len=%0d exp 1/10", pkt_valid, pkt_len); end
    read_word(7'd0, d);
    checks++; if (d !== 32'h04030201) begin errors++; $display("FAIL busy_rd0 got %h exp 04030201", d); end
    read_word(7'd1, d);
    checks++; if (d !== 32'h08070605) begin errors++; $display("FAIL busy_rd1 got %h exp 08070605", d); end
    rd_release = 1'b1; wr_start = 1'b1; wr_seq = 5'd1;
    @(negedge clk);
    rd_release = 1'b0; wr_start = 1'b0;
    checks++; if (pkt_valid !== 1'b0 || ep_ready !== 1'b0) begin errors++; $display("FAIL b2b_recv got valid=%0b ready=%0b exp 0/0", pkt_valid, ep_ready); end
    send_word(32'h11223344);
    end_pkt(1'b1, 2'd0, a, e);
    checks++; if (a !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL b2b_ack got %0b%0b exp 10", a, e); end
    @(negedge clk);
    checks++; if (pkt_len !== 10'd4 || exp_seq !== 5'd2) begin errors++; $display("FAIL b2b_len_seq got %0d/%0d exp 4/2", pkt_len, exp_seq); end
    read_word(7'd0, d);
    checks++; if (d !== 32'h11223344) begin errors++; $display("FAIL b2b_rd0 got %h exp 11223344", d); end
    release_buf();
    checks++; if (pkt_valid !== 1'b0 || ep_ready !== 1'b1) begin errors++; $display("FAIL release got valid=%0b ready=%0b exp 0/1", pkt_valid, ep_ready); end
  endtask

  task automatic test_crc_seq_fail();
    logic a, e;
    start_pkt(5'd2);
    send_word(32'h12345678);
    end_pkt(1'b0, 2'd0, a, e);
    checks++; if (a !== 1'b0 || e !== 1'b1) begin errors++; $display("FAIL crc_err got %0b%0b exp 01", a, e); end
    @(negedge clk);
    checks++; if (exp_seq !== 5'd2 || ep_ready !== 1'b1 || pkt_valid !== 1'b0) begin errors++; $display("FAIL crc_after got seq=%0d rdy=%0b vld=%0b exp 2/1/0", exp_seq, ep_ready, pkt_valid); end
    start_pkt(5'd5);
    send_word(32'h87654321);
    end_pkt(1'b1, 2'd0, a, e);
    checks++; if (a !== 1'b0 || e !== 1'b1) begin errors++; $display("FAIL seq_err got %0b%0b exp 01", a, e); end
    @(negedge clk);
    checks++; if (exp_seq !== 5'd2 || ep_ready !== 1'b1) begin errors++; $display("FAIL seq_after got seq=%0d rdy=%0b exp 2/1", exp_seq, ep_ready); end
  endtask

  task automatic test_overflow();
    logic a, e;
    logic [31:0] d;
    start_pkt(5'd2);
    for (int i = 0; i < 129; i++) send_word(32'hA5000000 | 32'(i));
    end_pkt(1'b1, 2'd0, a, e);
    checks++; if (a !== 1'b0 || e !== 1'b1) begin errors++; $display("FAIL ovf_err got %0b%0b exp 01", a, e); end
    @(negedge clk);
    checks++; if (ep_ready !== 1'b1 || exp_seq !== 5'd2) begin errors++; $display("FAIL ovf_after got rdy=%0b seq=%0d exp 1/2", ep_ready, exp_seq); end
    read_word(7'd0, d);
    checks++; if (d !== 32'hA5000000) begin errors++; $display("FAIL ovf_no_wrap got %h exp A5000000", d); end
    read_word(7'd127, d);
    checks++; if (d !== 32'hA500007F) begin errors++; $display("FAIL ovf_last got %h exp A500007F", d); end
    start_pkt(5'd2);
    for (int i = 0; i < 128; i++) send_word(32'hB6000000 | 32'(i));
    end_pkt(1'b1, 2'd0, a, e);
    checks++; if (a !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL max_ack got %0b%0b exp 10", a, e); end
    @(negedge clk);
    checks++; if (pkt_len !== 10'd512 || exp_seq !== 5'd3) begin errors++; $display("FAIL max_len_seq got %0d/%0d exp 512/3", pkt_len, exp_seq); end
    read_word(7'd127, d);
    checks++; if (d !== 32'hB600007F) begin errors++; $display("FAIL max_rd127 got %h exp B600007F", d); end
    release_buf();
  endtask

  task automatic test_seq_clr();
    logic a, e;
    logic [31:0] d;
    start_pkt(5'd3);
    send_word(32'h01010101);
    seq_clr = 1'b1;
    @(negedge clk);
    seq_clr = 1'b0;
    checks++; if (ep_ready !== 1'b1 || exp_seq !== 5'd0) begin errors++; $display("FAIL clr_recv got rdy=%0b seq=%0d exp 1/0", ep_ready, exp_seq); end
    end_pkt(1'b1, 2'd0, a, e);
    checks++; if (a !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL clr_no_pulse got %0b%0b exp 00", a, e); end
    start_pkt(5'd0);
    send_word(32'h00000055);
    end_pkt(1'b1, 2'd1, a, e);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL clr_next_ack got %0b exp 1", a); end
    @(negedge clk);
    checks++; if (pkt_len !== 10'd1 || exp_seq !== 5'd1) begin errors++; $display("FAIL clr_next_len got %0d/%0d exp 1/1", pkt_len, exp_seq); end
    release_buf();
    // seq_clr landing on the CHECK cycle
    start_pkt(5'd1);
    send_word(32'h00000066);
    wr_end = 1'b1; wr_crc_ok = 1'b1; wr_last_bytes = 2'd0;
    @(negedge clk);
    wr_end = 1'b0; seq_clr = 1'b1;
    #1;
    checks++; if (pkt_ack !== 1'b0 || pkt_err !== 1'b0) begin errors++; $display("FAIL clr_check_pulse got %0b%0b exp 00", pkt_ack, pkt_err); end
    @(negedge clk);
    seq_clr = 1'b0;
    checks++; if (ep_ready !== 1'b1 || exp_seq !== 5'd0) begin errors++; $display("FAIL clr_check_after got rdy=%0b seq=%0d exp 1/0", ep_ready, exp_seq); end
    start_pkt(5'd0);
    send_word(32'h00000099);
    end_pkt(1'b1, 2'd0, a, e);
    @(negedge clk);
    checks++; if (exp_seq !== 5'd1) begin errors++; $display("FAIL full_pre_seq got %0d exp 1", exp_seq); end
    seq_clr = 1'b1;
    @(negedge clk);
    seq_clr = 1'b0;
    checks++; if (pkt_valid !== 1'b1 || exp_seq !== 5'd0) begin errors++; $display("FAIL clr_full got vld=%0b seq=%0d exp 1/0", pkt_valid, exp_seq); end
    read_word(7'd0, d);
    checks++; if (d !== 32'h00000099) begin errors++; $display("FAIL clr_full_rd got %h exp 00000099", d); end
    release_buf();
    start_pkt(5'd0);
    end_pkt(1'b1, 2'd0, a, e);
    checks++; if (a !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL zlp_ack got %0b%0b exp 10", a, e); end
    @(negedge clk);
    checks++; if (pkt_len !== 10'd0 || exp_seq !== 5'd1) begin errors++; $display("FAIL zlp_len got %0d/%0d exp 0/1", pkt_len, exp_seq); end
    release_buf();
  endtask

  task automatic test_reset_mid();
    logic a, e;
    logic [31:0] d;
    start_pkt(5'd1);
    send_word(32'h0000AAAA);
    reset = 1'b1;
    #1;
    checks++; if (ep_ready !== 1'b1 || exp_seq !== 5'd0) begin errors++; $display("FAIL rst_recv got rdy=%0b seq=%0d exp 1/0", ep_ready, exp_seq); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_pkt(5'd0);
    send_word(32'hABCD0123);
    end_pkt(1'b1, 2'd0, a, e);
    @(negedge clk);
    read_word(7'd0, d);
    checks++; if (d !== 32'hABCD0123 || pkt_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_full got %h/%0b exp ABCD0123/1", d, pkt_valid); end
    reset = 1'b1;
    #1;
    checks++; if (pkt_valid !== 1'b0 || ep_ready !== 1'b1) begin errors++; $display("FAIL rst_full_state got vld=%0b rdy=%0b exp 0/1", pkt_valid, ep_ready); end
    checks++; if (pkt_len !== 10'd0 || rd_dat !== 32'h0 || exp_seq !== 5'd0) begin errors++; $display("FAIL rst_full_regs got len=%0d rd=%h seq=%0d exp 0/0/0", pkt_len, rd_dat, exp_seq); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_pkt(5'd0);
    send_word(32'h00000077);
    end_pkt(1'b1, 2'd3, a, e);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL rst_next_ack got %0b exp 1", a); end
    @(negedge clk);
    checks++; if (pkt_len !== 10'd3 || exp_seq !== 5'd1) begin errors++; $display("FAIL rst_next_len got %0d/%0d exp 3/1", pkt_len, exp_seq); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_busy();
    test_crc_seq_fail();
    test_overflow();
    test_seq_clr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
